// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and width helpers for the truth-table sweeper.
// Both the FSM module and its bus interface derive their widths from these definitions.
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    FINISH
  } tt_state_e;

  function automatic int tt_width(input int n_in);
    return 1 << n_in;
  endfunction

  localparam int DEF_N_IN = 3;
  localparam int DEF_TT_W = tt_width(DEF_N_IN);

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Bus between test control / circuit under characterisation (master) and the sweeper (slave).
// The width parameter must match the N_IN of the attached sweeper.
interface truth_table_sweeper_if
  import tt_pkg::*;
#(
  parameter int N_IN = DEF_N_IN
) ();

  localparam int TT_W = tt_width(N_IN);

  logic            start;
  logic            abort;
  logic [TT_W-1:0] expected_tt;
  logic [N_IN-1:0] dut_vec;
  logic            dut_out;
  logic            busy;
  logic            done;
  logic [TT_W-1:0] tt_out;
  logic            match;

  modport master (
    output start, abort, expected_tt, dut_out,
    input  dut_vec, busy, done, tt_out, match
  );

  modport slave (
    input  start, abort, expected_tt, dut_out,
    output dut_vec, busy, done, tt_out, match
  );

endinterface

// File: rtl/truth_table_sweeper_bit_sync.sv
// Multi-flop synchroniser bringing the asynchronous circuit output into the clk domain.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb sync_d[0] = d;

  generate
    for (genvar gi = 1; gi < STAGES; gi++) begin : g_chain
      always_comb sync_d[gi] = sync_q[gi-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every input vector of a combinational circuit, samples its synchronised
// output after a settle window and rebuilds the truth-table ID, optionally matching it.
module truth_table_sweeper
  import tt_pkg::*;
#(
  parameter int N_IN          = DEF_N_IN,
  parameter int SETTLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  truth_table_sweeper_if.slave bus
);

  localparam int TT_W    = tt_width(N_IN);
  localparam int CNT_MAX = SETTLE_CYCLES + SYNC_STAGES - 1;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);
  localparam logic [N_IN:0]    VEC_LAST = (N_IN + 1)'(TT_W - 1);

  tt_state_e       state_q,  state_d;
  logic [N_IN:0]   vec_q,    vec_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [TT_W-1:0] shadow_q, shadow_d;
  logic [TT_W-1:0] exp_q,    exp_d;
  logic [TT_W-1:0] tt_q,     tt_d;
  logic            match_q,  match_d;
  logic            done_q,   done_d;
  logic            out_sync;

  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.dut_out),
    .q     (out_sync)
  );

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    exp_d    = exp_q;
    tt_d     = tt_q;
    match_d  = match_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          exp_d    = bus.expected_tt;
          shadow_d = '0;
          vec_d    = '0;
          cnt_d    = '0;
          state_d  = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == CNT_LAST) state_d = SAMPLE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      SAMPLE: begin
        shadow_d[vec_q[N_IN-1:0]] = out_sync;
        if (vec_q == VEC_LAST) begin
          state_d = FINISH;
        end else begin
          vec_d   = vec_q + 1'b1;
          cnt_d   = '0;
          state_d = DRIVE;
        end
      end
      FINISH: begin
        tt_d    = shadow_q;
        match_d = (shadow_q == exp_q);
        done_d  = 1'b1;
        vec_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides everything outside IDLE, including a pending FINISH result.
    if (bus.abort && (state_q != IDLE)) begin
      state_d = IDLE;
      vec_d   = '0;
      cnt_d   = '0;
      tt_d    = tt_q;
      match_d = match_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      exp_q    <= '0;
      tt_q     <= '0;
      match_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      exp_q    <= exp_d;
      tt_q     <= tt_d;
      match_q  <= match_d;
      done_q   <= done_d;
    end
  end

  assign bus.dut_vec = vec_q[N_IN-1:0];
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.tt_out  = tt_q;
  assign bus.match   = match_q;

endmodule
